mul_seq_core: RTL and testbench



---
 rtl/mul_seq_core.sv | 130 +++++++++++++
 tb/tb_mul_seq_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_core.sv
// Sequential signed multiplier: magnitude shift-add, one multiplier bit per clock,
// followed by a single two's-complement sign fix-up before the product is published.
module mul_seq_core #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     m_in,
  input  logic [WIDTH-1:0]     q_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int AW = WIDTH + 1;
  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_NEG,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PW-1:0]   product_q, product_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mag_m_q, mag_m_d;
  logic [WIDTH-1:0] mag_q_q, mag_q_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d;

  logic [WIDTH-1:0] m_abs;
  logic [WIDTH-1:0] q_abs;
  logic [AW-1:0]    acc_sum;
  logic [PW-1:0]    mag_prod;

  // The most-negative operand negates to itself, which read unsigned is exactly 2^(W-1).
  assign m_abs    = m_in[WIDTH-1] ? (~m_in + WIDTH'(1)) : m_in;
  assign q_abs    = q_in[WIDTH-1] ? (~q_in + WIDTH'(1)) : q_in;
  assign acc_sum  = acc_q + {1'b0, mag_m_q};
  assign mag_prod = {acc_q[WIDTH-1:0], mag_q_q};

  always_comb begin
    state_d   = state_q;
    product_d = product_q;
    acc_d     = acc_q;
    mag_m_d   = mag_m_q;
    mag_q_d   = mag_q_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sign_d  = m_in[WIDTH-1] ^ q_in[WIDTH-1];
          mag_m_d = m_abs;
          mag_q_d = q_abs;
          acc_d   = '0;
          cnt_d   = '0;
          if ((m_in == '0) || (q_in == '0)) begin
            state_d   = S_DONE;
            product_d = '0;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        // Add-then-shift: the bit leaving the accumulator lands in the multiplier MSB.
        if (mag_q_q[0]) begin
          acc_d   = {1'b0, acc_sum[AW-1:1]};
          mag_q_d = {acc_sum[0], mag_q_q[WIDTH-1:1]};
        end else begin
          acc_d   = {1'b0, acc_q[AW-1:1]};
          mag_q_d = {acc_q[0], mag_q_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_NEG;
        end
      end
      S_NEG: begin
        product_d = sign_q ? (~mag_prod + PW'(1)) : mag_prod;
        state_d   = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_CALC) || (state_d == S_NEG);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      acc_q     <= '0;
      mag_m_q   <= '0;
      mag_q_q   <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
      acc_q     <= acc_d;
      mag_m_q   <= mag_m_d;
      mag_q_q   <= mag_q_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mul_seq_core.sv
// Randomized bench for mul_seq_core: a cycle-level reference of busy/done/product
// compared every cycle, plus directed operations pinned to hand-computed results.
module tb_mul_seq_core;

  localparam int W  = 32;
  localparam int PW = 2 * W;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  m_in;
  logic [W-1:0]  q_in;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  bit chk_en   = 0;

  // Reference state, advanced once per rising edge from the bench's own inputs.
  logic          exp_busy = 1'b0;
  logic          exp_done = 1'b0;
  logic [PW-1:0] exp_prod = '0;
  logic [PW-1:0] pending  = '0;
  int            rem      = 0;

  mul_seq_core #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .m_in    (m_in),
    .q_in    (q_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [PW-1:0] sa;
    logic signed [PW-1:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a non-zero multiply keeps busy for W+1 cycles and then publishes the
  // product together with a one-cycle done; zero operands finish on the next cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_prod = '0;
        rem      = 0;
      end else if (exp_busy) begin
        exp_done = 1'b0;
        rem--;
        if (rem == 0) begin
          exp_busy = 1'b0;
          exp_done = 1'b1;
          exp_prod = pending;
        end
      end else if (start) begin
        if ((m_in == '0) || (q_in == '0)) begin
          exp_done = 1'b1;
          exp_prod = '0;
        end else begin
          exp_busy = 1'b1;
          exp_done = 1'b0;
          rem      = W + 1;
          pending  = ref_mul(m_in, q_in);
        end
      end else begin
        exp_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {63'd0, busy}, {63'd0, exp_busy});
      chk("cyc_done", {63'd0, done}, {63'd0, exp_done});
      chk("cyc_product", product, exp_prod);
      if (busy && done) chk("busy_done_exclusive", 64'd1, 64'd0);
    end
  end

  // Present operands now; they are accepted at the next rising edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    m_in  = a;
    q_in  = b;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start   = 1'b0;
    m_in    = $urandom;
    q_in    = $urandom;
  endtask

  // Returns at the falling edge inside the done cycle.
  task automatic wait_done(input string name, input logic [PW-1:0] exp, input int exp_lat);
    int lat;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (!done) begin
      chk({name, "_timeout"}, 64'd0, 64'd1);
    end else begin
      lat = cyc - acc_cyc + 1;
      chk({name, "_latency"}, PW'(lat), PW'(exp_lat));
      chk({name, "_product"}, product, exp);
      chk({name, "_busy_low"}, {63'd0, busy}, 64'd0);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corners [5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    case ($urandom_range(0, 4))
      0:       return corners[$urandom_range(0, 4)];
      1:       return W'($signed(9'($urandom_range(0, 511))));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [PW-1:0] r;
    rst   = 1'b1;
    start = 1'b0;
    m_in  = '0;
    q_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_product", product, 64'd0);
    chk_en = 1'b1;
    rst    = 1'b0;

    issue(32'd3, 32'd5);
    wait_done("basic", 64'd15, 34);
    chk("model_basic", exp_prod, 64'd15);
    repeat (3) @(negedge clk);
    chk("basic_hold", product, 64'd15);

    issue(32'hFFFF_FFF9, 32'd6);
    wait_done("neg7x6", 64'hFFFF_FFFF_FFFF_FFD6, 34);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("m1xm1", 64'd1, 34);
    issue(32'h8000_0000, 32'h8000_0000);
    wait_done("minxmin", 64'h4000_0000_0000_0000, 34);
    chk("model_minxmin", exp_prod, 64'h4000_0000_0000_0000);
    issue(32'h7FFF_FFFF, 32'h8000_0000);
    wait_done("maxxmin", 64'hC000_0000_8000_0000, 34);

    issue(32'd0, 32'h1234_5678);
    wait_done("zero_m", 64'd0, 1);
    issue(32'hFFFF_FFFB, 32'd0);
    wait_done("zero_q_neg_m", 64'd0, 1);

    // Start pulse during CALC must be ignored.
    issue(32'd1000, 32'hFFFF_FC18);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    m_in  = 32'd77;
    q_in  = 32'd99;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("start_ignored", 64'hFFFF_FFFF_FFF0_BDC0, 34);

    // Hold start through the done cycle: next operation with no IDLE gap.
    issue(32'd9, 32'd11);
    wait_done("b2b_first", 64'd99, 34);
    issue(32'd2, 32'hFFFF_FFFD);
    @(negedge clk);
    chk("b2b_busy_now", {63'd0, busy}, 64'd1);
    wait_done("b2b_second", 64'hFFFF_FFFF_FFFF_FFFA, 34);

    // Reset asserted so that it lands on CALC iteration 10.
    issue(32'h1234_5678, 32'hFEDC_BA98);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_product", product, 64'd0);
    rst = 1'b0;
    issue(32'd4, 32'd4);
    wait_done("after_rst", 64'd16, 34);

    for (int n = 0; n < 40; n++) begin
      a = pick_operand();
      b = pick_operand();
      r = ref_mul(a, b);
      if ($urandom_range(0, 2) != 0) begin
        @(posedge clk);
        #1;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      issue(a, b);
      if ((a != '0) && (b != '0) && ($urandom_range(0, 3) == 0)) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      wait_done("rand", r, ((a == '0) || (b == '0)) ? 1 : 34);
    end

    @(posedge clk);
    #1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
